// File: rtl/sd_cmd_phy_pkg.sv
// Shared definitions for the SD command-line PHY.
//   state_t    : controller states
//   resp_t     : response-type encodings presented on resp_type
//   CRC7_POLY  : x^7 + x^3 + 1, with the x^7 term implicit
package sd_cmd_phy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_TURN,
    ST_WAIT_RESP,
    ST_RECEIVE,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    RESP_NONE        = 2'b00,
    RESP_SHORT       = 2'b01,
    RESP_LONG        = 2'b10,
    RESP_SHORT_NOCRC = 2'b11
  } resp_t;

  localparam logic [6:0] CRC7_POLY = 7'h09;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 generator, one bit per clock, MSB of the message first.
//   clk, rst_n : clock and asynchronous active-low reset
//   clear      : zero the remainder (takes priority over enable)
//   enable     : fold data_in into the remainder this cycle
//   data_in    : message bit
//   crc_out    : current 7-bit remainder
module sd_crc7
  import sd_cmd_phy_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  input  logic       data_in,
  output logic [6:0] crc_out
);

  logic feedback;

  assign feedback = data_in ^ crc_out[6];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_out <= '0;
    end else if (clear) begin
      crc_out <= '0;
    end else if (enable) begin
      crc_out <= {crc_out[5:0], 1'b0} ^ (feedback ? CRC7_POLY : 7'h00);
    end
  end

endmodule

// File: rtl/sd_cmd_phy_gen2.sv
// SD command-line PHY: serialises a 48-bit command with generated CRC7 and
// end bit, then receives a none/short/long response, checking CRC7, end bit
// and a start-bit timeout.
// Build option: define SD_CMD_PHY_CRC_CHECK_EN to include the response CRC7
// checker; without it crc_error is tied low.
// Ports:
//   sd_clock, reset   : clock, asynchronous active-low reset
//   strobe_in/ack_out : host command request / one-cycle acceptance pulse
//   cmd_to_send       : start, direction, index and argument bits
//   resp_type         : expected response type (see resp_t)
//   strobe_out/ack_in : result valid (held) / host consumed it
//   idle_in           : synchronous abort to IDLE, highest priority
//   response          : received frame, right-aligned
//   crc_error, end_bit_error, command_timeout : response status flags
//   busy              : not in IDLE
//   cmd_out/cmd_oe/cmd_in : CMD pad data out, output enable, data in
module sd_cmd_phy_gen2
  import sd_cmd_phy_pkg::*;
#(
  parameter int CMD_W          = 48,
  parameter int SHORT_RESP_W   = 48,
  parameter int LONG_RESP_W    = 136,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TURNAROUND     = 2
) (
  input  logic                   sd_clock,
  input  logic                   reset,
  input  logic                   strobe_in,
  input  logic                   ack_in,
  input  logic                   idle_in,
  input  logic [CMD_W-9:0]       cmd_to_send,
  input  logic [1:0]             resp_type,
  output logic                   ack_out,
  output logic                   strobe_out,
  output logic [LONG_RESP_W-1:0] response,
  output logic                   crc_error,
  output logic                   end_bit_error,
  output logic                   command_timeout,
  output logic                   busy,
  output logic                   cmd_out,
  output logic                   cmd_oe,
  input  logic                   cmd_in
);

  localparam int CMD_BITS = CMD_W - 8;
  localparam int CNT_MAX  = (LONG_RESP_W > TIMEOUT_CYCLES) ? LONG_RESP_W : TIMEOUT_CYCLES;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CRC_FIRST  = CNT_W'(CMD_BITS);
  localparam logic [CNT_W-1:0] SEND_LAST  = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(TURNAROUND - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(SHORT_RESP_W - 1);
  localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_RESP_W - 1);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [CMD_BITS-1:0] cmd_sh;
  resp_t               rtype;
  logic [6:0]          tx_crc;
  logic [2:0]          crc_idx;
  logic [CNT_W-1:0]    rx_last;
  logic                accept;
  logic                tx_crc_en;
  logic                rx_last_bit;

  assign accept      = (state == ST_IDLE) && strobe_in && !idle_in;
  assign tx_crc_en   = (state == ST_SEND) && (cnt < CRC_FIRST) && !idle_in;
  assign rx_last     = (rtype == RESP_LONG) ? LONG_LAST : SHORT_LAST;
  assign rx_last_bit = (state == ST_RECEIVE) && (cnt == rx_last);
  // CRC bits are sent MSB first: bit position CMD_BITS maps to crc[6].
  assign crc_idx     = 3'(CMD_W - 2 - int'(cnt));
  assign busy        = (state != ST_IDLE);

  sd_crc7 u_tx_crc (
    .clk     (sd_clock),
    .rst_n   (reset),
    .clear   (accept),
    .enable  (tx_crc_en),
    .data_in (cmd_sh[CMD_BITS-1]),
    .crc_out (tx_crc)
  );

  // State register. Pad controls decode from it, so an asynchronous reset
  // releases the line immediately.
  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      state <= state_nxt;
    end
  end

  always_comb begin
    // NOTE: every output and the next state get a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_nxt  = state;
    ack_out    = 1'b0;
    strobe_out = 1'b0;
    cmd_oe     = 1'b0;
    cmd_out    = 1'b1;
    case (state)
      ST_IDLE: begin
        if (strobe_in) begin
          ack_out   = 1'b1;
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        cmd_oe = 1'b1;
        if (cnt < CRC_FIRST)      cmd_out = cmd_sh[CMD_BITS-1];
        else if (cnt < SEND_LAST) cmd_out = tx_crc[crc_idx];
        else                      cmd_out = 1'b1;
        if (cnt == SEND_LAST) state_nxt = (rtype == RESP_NONE) ? ST_DONE : ST_TURN;
      end
      ST_TURN: begin
        if (cnt == TURN_LAST) state_nxt = ST_WAIT_RESP;
      end
      ST_WAIT_RESP: begin
        // A start bit on the final wait cycle wins over the timeout.
        if (!cmd_in)                state_nxt = ST_RECEIVE;
        else if (cnt == WAIT_LAST)  state_nxt = ST_DONE;
      end
      ST_RECEIVE: begin
        if (cnt == rx_last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        strobe_out = 1'b1;
        if (ack_in) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (idle_in) begin
      state_nxt = ST_IDLE;
      ack_out   = 1'b0;
    end
  end

  // Datapath: cnt counts bits sent, turnaround cycles, wait cycles, or bits
  // received (start bit included), depending on the state.
  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      cnt             <= '0;
      cmd_sh          <= '0;
      rtype           <= RESP_NONE;
      // NOTE: response is a register bank, not a memory, so it is reset like
      // any other flop to guarantee a clean zero after power-up.
      response        <= '0;
      command_timeout <= 1'b0;
      end_bit_error   <= 1'b0;
    end else if (idle_in) begin
      cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (strobe_in) begin
            cmd_sh          <= cmd_to_send;
            rtype           <= resp_t'(resp_type);
            response        <= '0;
            command_timeout <= 1'b0;
            end_bit_error   <= 1'b0;
            cnt             <= '0;
          end
        end
        ST_SEND: begin
          cmd_sh <= cmd_sh << 1;
          cnt    <= (cnt == SEND_LAST) ? '0 : cnt + CNT_ONE;
        end
        ST_TURN: begin
          cnt <= (cnt == TURN_LAST) ? '0 : cnt + CNT_ONE;
        end
        ST_WAIT_RESP: begin
          if (!cmd_in) begin
            response <= {response[LONG_RESP_W-2:0], cmd_in};
            cnt      <= CNT_ONE;
          end else if (cnt == WAIT_LAST) begin
            command_timeout <= 1'b1;
            response        <= '0;
            cnt             <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_RECEIVE: begin
          response <= {response[LONG_RESP_W-2:0], cmd_in};
          if (cnt == rx_last) begin
            end_bit_error <= !cmd_in;
            cnt           <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SD_CMD_PHY_CRC_CHECK_EN
  logic [6:0]       rx_crc;
  logic [CNT_W-1:0] rx_pos;
  logic             rx_bit;
  logic             rx_crc_en;

  // rx_pos is the index of the bit on cmd_in (start bit = 0).
  assign rx_pos = (state == ST_RECEIVE) ? cnt : '0;
  assign rx_bit = !idle_in && (((state == ST_WAIT_RESP) && !cmd_in) || (state == ST_RECEIVE));
  // Long responses skip start, direction and six reserved bits.
  assign rx_crc_en = rx_bit &&
    ((rtype == RESP_LONG) ? ((rx_pos >= CNT_W'(8)) && (rx_pos < CNT_W'(LONG_RESP_W - 8)))
                          : (rx_pos < CNT_W'(SHORT_RESP_W - 8)));

  sd_crc7 u_rx_crc (
    .clk     (sd_clock),
    .rst_n   (reset),
    .clear   (accept),
    .enable  (rx_crc_en),
    .data_in (cmd_in),
    .crc_out (rx_crc)
  );

  // On the end bit, response[6:0] still holds the seven received CRC bits.
  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      crc_error <= 1'b0;
    end else if (accept) begin
      crc_error <= 1'b0;
    end else if (rx_last_bit && !idle_in) begin
      crc_error <= (rtype != RESP_SHORT_NOCRC) && (response[6:0] != rx_crc);
    end
  end
`else
  assign crc_error = 1'b0;
`endif

endmodule

// File: tb/tb_sd_cmd_phy_gen2.sv
// Directed self-checking bench for sd_cmd_phy_gen2. Inputs change and outputs
// are sampled on the falling edge; the DUT acts on the rising edge.
module tb_sd_cmd_phy_gen2;

  logic         sd_clock = 1'b0;
  logic         reset    = 1'b0;
  logic         strobe_in = 1'b0;
  logic         ack_in    = 1'b0;
  logic         idle_in   = 1'b0;
  logic         cmd_in    = 1'b1;
  logic [39:0]  cmd_to_send = '0;
  logic [1:0]   resp_type   = 2'b00;
  logic         ack_out, strobe_out, crc_error, end_bit_error;
  logic         command_timeout, busy, cmd_out, cmd_oe;
  logic [135:0] response;

  int checks = 0;
  int errors = 0;

  sd_cmd_phy_gen2 dut (
    .sd_clock        (sd_clock),
    .reset           (reset),
    .strobe_in       (strobe_in),
    .ack_in          (ack_in),
    .idle_in         (idle_in),
    .cmd_to_send     (cmd_to_send),
    .resp_type       (resp_type),
    .ack_out         (ack_out),
    .strobe_out      (strobe_out),
    .response        (response),
    .crc_error       (crc_error),
    .end_bit_error   (end_bit_error),
    .command_timeout (command_timeout),
    .busy            (busy),
    .cmd_out         (cmd_out),
    .cmd_oe          (cmd_oe),
    .cmd_in          (cmd_in)
  );

  always #5 sd_clock = ~sd_clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference CRC7 over v[msb] down to v[lsb].
  function automatic logic [6:0] crc7_ref(input logic [135:0] v, input int msb, input int lsb);
    logic [6:0] c = '0;
    for (int i = msb; i >= lsb; i--) begin
      logic top = c[6] ^ v[i];
      c = {c[5:0], 1'b0};
      if (top) c = c ^ 7'b000_1001;
    end
    return c;
  endfunction

  // Called on a falling edge in IDLE; returns on the falling edge after the
  // last command bit.
  task automatic send_cmd(input logic [39:0] c, input logic [1:0] t, input logic [47:0] exp_serial);
    logic [47:0] got = '0;
    int          oe_n = 0;
    cmd_to_send = c;
    resp_type   = t;
    strobe_in   = 1'b1;
    #1;
    check_bit("ack_out_pulse", ack_out, 1'b1);
    @(negedge sd_clock);
    strobe_in = 1'b0;
    check_bit("ack_out_one_cycle", ack_out, 1'b0);
    for (int i = 0; i < 48; i++) begin
      got  = {got[46:0], cmd_out};
      oe_n = oe_n + (cmd_oe ? 1 : 0);
      @(negedge sd_clock);
    end
    check_vec("cmd_serial", {88'h0, got}, {88'h0, exp_serial});
    check_int("cmd_oe_cycles", oe_n, 48);
    check_bit("line_released", cmd_oe, 1'b0);
  endtask

  // Called right after send_cmd; idles through turnaround plus gap cycles,
  // then drives len bits of frame MSB first.
  task automatic card_reply(input logic [135:0] frame, input int len, input int gap);
    repeat (2 + gap) @(negedge sd_clock);
    for (int i = len - 1; i >= 0; i--) begin
      cmd_in = frame[i];
      @(negedge sd_clock);
    end
    cmd_in = 1'b1;
  endtask

  task automatic host_ack();
    ack_in = 1'b1;
    @(negedge sd_clock);
    ack_in = 1'b0;
    check_bit("strobe_drops_after_ack", strobe_out, 1'b0);
    check_bit("idle_after_ack", busy, 1'b0);
  endtask

  logic         crc_bad_exp;
  logic [119:0] cid;
  logic [6:0]   crc_l;
  logic [135:0] r2;
  int           k;

  initial begin
`ifdef SD_CMD_PHY_CRC_CHECK_EN
    crc_bad_exp = 1'b1;
`else
    crc_bad_exp = 1'b0;
`endif
    cid   = 120'h11_2233_4455_6677_8899_AABB_CCDD_EEFF;
    crc_l = crc7_ref({8'h3F, cid, 8'h00}, 127, 8);
    r2    = {8'h3F, cid, crc_l, 1'b1};

    // Reset state
    repeat (3) @(negedge sd_clock);
    reset = 1'b1;
    @(negedge sd_clock);
    check_bit("rst_ack_out", ack_out, 1'b0);
    check_bit("rst_strobe_out", strobe_out, 1'b0);
    check_vec("rst_response", response, '0);
    check_bit("rst_crc_error", crc_error, 1'b0);
    check_bit("rst_end_bit_error", end_bit_error, 1'b0);
    check_bit("rst_timeout", command_timeout, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_cmd_out", cmd_out, 1'b1);
    check_bit("rst_cmd_oe", cmd_oe, 1'b0);

    // CMD0, no response; ack in the same cycle strobe_out rises
    send_cmd(40'h40_0000_0000, 2'b00, 48'h40_0000_0000_95);
    check_bit("cmd0_strobe", strobe_out, 1'b1);
    check_vec("cmd0_response", response, '0);
    check_bit("cmd0_crc_error", crc_error, 1'b0);
    check_bit("cmd0_end_err", end_bit_error, 1'b0);
    check_bit("cmd0_timeout", command_timeout, 1'b0);
    host_ack();

    // CMD8 with R7 reply after 5 idle cycles; result held until ack
    send_cmd(40'h48_0000_01AA, 2'b01, 48'h48_0000_01AA_87);
    card_reply({88'h0, 48'h08_0000_01AA_13}, 48, 5);
    check_bit("cmd8_strobe", strobe_out, 1'b1);
    check_vec("cmd8_response", response, {88'h0, 48'h08_0000_01AA_13});
    check_bit("cmd8_crc_error", crc_error, 1'b0);
    check_bit("cmd8_end_err", end_bit_error, 1'b0);
    check_bit("cmd8_timeout", command_timeout, 1'b0);
    repeat (3) @(negedge sd_clock);
    check_bit("cmd8_strobe_held", strobe_out, 1'b1);
    check_vec("cmd8_response_held", response, {88'h0, 48'h08_0000_01AA_13});
    host_ack();

    // Same exchange with corrupted response CRC byte
    send_cmd(40'h48_0000_01AA, 2'b01, 48'h48_0000_01AA_87);
    card_reply({88'h0, 48'h08_0000_01AA_15}, 48, 5);
    check_vec("badcrc_response", response, {88'h0, 48'h08_0000_01AA_15});
    check_bit("badcrc_crc_error", crc_error, crc_bad_exp);
    check_bit("badcrc_end_err", end_bit_error, 1'b0);
    host_ack();

    // Same corrupted reply as R3 type: CRC never flagged
    send_cmd(40'h48_0000_01AA, 2'b11, 48'h48_0000_01AA_87);
    card_reply({88'h0, 48'h08_0000_01AA_15}, 48, 5);
    check_bit("r3_crc_error", crc_error, 1'b0);
    host_ack();

    // Timeout: cmd_in stays high after turnaround
    send_cmd(40'h48_0000_01AA, 2'b01, 48'h48_0000_01AA_87);
    repeat (2) @(negedge sd_clock);
    k = 0;
    while (!strobe_out && k < 200) begin
      @(negedge sd_clock);
      k++;
    end
    check_int("timeout_latency", k, 64);
    check_bit("timeout_flag", command_timeout, 1'b1);
    check_vec("timeout_response", response, '0);
    check_bit("timeout_end_err", end_bit_error, 1'b0);
    host_ack();

    // Start bit on the very last wait cycle is accepted
    send_cmd(40'h48_0000_01AA, 2'b01, 48'h48_0000_01AA_87);
    card_reply({88'h0, 48'h08_0000_01AA_13}, 48, 63);
    check_bit("late_start_timeout", command_timeout, 1'b0);
    check_vec("late_start_response", response, {88'h0, 48'h08_0000_01AA_13});
    host_ack();

    // Long R2 response with valid CRC
    send_cmd(40'h42_0000_0000, 2'b10, 48'h42_0000_0000_4D);
    card_reply(r2, 136, 3);
    check_bit("r2_strobe", strobe_out, 1'b1);
    check_vec("r2_response", response, r2);
    check_bit("r2_crc_error", crc_error, 1'b0);
    check_bit("r2_end_err", end_bit_error, 1'b0);
    host_ack();

    // Long response with end bit 0
    send_cmd(40'h42_0000_0000, 2'b10, 48'h42_0000_0000_4D);
    card_reply({r2[135:1], 1'b0}, 136, 3);
    check_vec("r2_badend_response", response, {r2[135:1], 1'b0});
    check_bit("r2_badend_end_err", end_bit_error, 1'b1);
    check_bit("r2_badend_crc_error", crc_error, 1'b0);
    host_ack();

    // Abort with idle_in at transmit bit 20
    cmd_to_send = 40'h51_0000_0010;
    resp_type   = 2'b01;
    strobe_in   = 1'b1;
    @(negedge sd_clock);
    strobe_in = 1'b0;
    repeat (20) @(negedge sd_clock);
    check_bit("abort_driving_before", cmd_oe, 1'b1);
    idle_in = 1'b1;
    @(negedge sd_clock);
    idle_in = 1'b0;
    check_bit("abort_cmd_oe", cmd_oe, 1'b0);
    check_bit("abort_cmd_out", cmd_out, 1'b1);
    check_bit("abort_busy", busy, 1'b0);
    check_bit("abort_strobe", strobe_out, 1'b0);
    repeat (5) @(negedge sd_clock);
    check_bit("abort_stays_idle", busy, 1'b0);
    check_bit("abort_no_strobe", strobe_out, 1'b0);
    send_cmd(40'h40_0000_0000, 2'b00, 48'h40_0000_0000_95);
    check_bit("post_abort_strobe", strobe_out, 1'b1);
    host_ack();

    // Asynchronous reset mid-frame releases the line at once
    cmd_to_send = 40'h48_0000_01AA;
    resp_type   = 2'b01;
    strobe_in   = 1'b1;
    @(negedge sd_clock);
    strobe_in = 1'b0;
    repeat (10) @(negedge sd_clock);
    check_bit("rstmid_driving_before", cmd_oe, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check_bit("rstmid_cmd_oe", cmd_oe, 1'b0);
    check_bit("rstmid_cmd_out", cmd_out, 1'b1);
    check_bit("rstmid_busy", busy, 1'b0);
    @(negedge sd_clock);
    reset = 1'b1;
    @(negedge sd_clock);
    check_bit("rstmid_idle_after", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
